// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: FSM state encoding and the
// default tick divisor that the counter top also uses.
package btn_evt_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        PRESS1 = ST_PRESS1,
        WAIT2  = ST_WAIT2,
        PRESS2 = ST_PRESS2,
        LONG   = ST_LONG
    } state_t;

    // 100 MHz clock down to a 1 kHz (1 ms) timing tick
    localparam int DEFAULT_TICK_DIV = 100_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_event_decoder_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clock cycles.
module tick_gen
    import btn_evt_pkg::*;
#(
    parameter int DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_reg;

    assign tick = (presc_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into short, double, long and auto-repeat
// single-cycle events, timed by a millisecond tick.
module button_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int LONG_T   = 1000,
    parameter int REPEAT_T = 200,
    parameter int DCLICK_T = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_short,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_busy
);

    localparam int            MAX_T       = max3(LONG_T, REPEAT_T, DCLICK_T);
    localparam int            CW          = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_T - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_T - 1);
    localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_T - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;

    // event vector bit order: 0 short, 1 double, 2 long, 3 repeat
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    evt_reg, evt_next;
    logic          busy_reg;
    logic          tick;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_next = state_reg;
        evt_next   = 4'b0000;
        cnt_next   = cnt_reg;
        if (tick && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CW'(1);
        end

        // Button edges are tested first so they win over a same-cycle timeout.
        case (state_reg)
            IDLE: begin
                if (i_btn) state_next = PRESS1;
            end
            PRESS1: begin
                if (!i_btn) begin
                    state_next = WAIT2;
                end else if (tick && (cnt_reg == LONG_LAST)) begin
                    state_next  = LONG;
                    evt_next[2] = 1'b1;
                end
            end
            WAIT2: begin
                if (i_btn) begin
                    state_next  = PRESS2;
                    evt_next[1] = 1'b1;
                end else if (tick && (cnt_reg == DCLICK_LAST)) begin
                    state_next  = IDLE;
                    evt_next[0] = 1'b1;
                end
            end
            PRESS2: begin
                if (!i_btn) state_next = IDLE;
            end
            LONG: begin
                if (!i_btn) begin
                    state_next = IDLE;
                end else if (tick && (cnt_reg == REPEAT_LAST)) begin
                    evt_next[3] = 1'b1;
                    cnt_next    = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next != state_reg) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            evt_reg   <= 4'b0000;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            evt_reg   <= evt_next;
            busy_reg  <= (state_next != IDLE);
        end
    end

    assign o_short  = evt_reg[0];
    assign o_double = evt_reg[1];
    assign o_long   = evt_reg[2];
    assign o_repeat = evt_reg[3];
    assign o_busy   = busy_reg;

endmodule
